// File: rtl/keypad4x4_scan.sv
// keypad4x4_scan
//   Scanned 4x4 matrix-keypad reader. One column is driven low at a time,
//   the row lines are read back through a synchronizer, and each full scan
//   frame is classified as empty, single-key or multi-key. A debounce FSM
//   turns stable frames into a single-key event interface.
//
// Ports
//   clk        system clock
//   nrst       asynchronous active-low reset
//   row        keypad rows, active-low, asynchronous to clk
//   col        column drive, one-hot-low
//   key        code of last accepted key (4*row_index + col_index)
//   key_valid  one-clock pulse when a press is accepted
//   key_held   high while the accepted key is still considered pressed
module keypad4x4_scan #(
  parameter logic [25:0] SCAN_MAX        = 26'd26999,
  parameter logic [3:0]  DEBOUNCE_FRAMES = 4'd5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [25:0] divCnt_q, divCnt_d;
  logic        tick;
  logic [3:0]  col_q, col_d;
  logic [3:0]  rowMeta_q, rowSync_q;
  logic [1:0]  lowAcc_q, lowAcc_d;
  logic [3:0]  candAcc_q, candAcc_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_q, key_d;
  logic        keyValid_q, keyValid_d;
  logic        keyHeld_q, keyHeld_d;

  logic [1:0]  colIdx;
  logic [2:0]  sampleLows;
  logic [1:0]  sampleRow;
  logic [1:0]  baseLows;
  logic [2:0]  lowSum;
  logic [1:0]  frameLows;
  logic [3:0]  frameCand;
  logic        frameEval;
  logic        isEmpty;
  logic        isSingle;
  logic [3:0]  cntInc;

  assign tick      = (divCnt_q == SCAN_MAX);
  assign divCnt_d  = tick ? 26'd0 : divCnt_q + 26'd1;
  assign col_d     = tick ? {col_q[2:0], col_q[3]} : col_q;

  always_comb begin
    case (col_q)
      4'b1101: colIdx = 2'd1;
      4'b1011: colIdx = 2'd2;
      4'b0111: colIdx = 2'd3;
      default: colIdx = 2'd0;
    endcase
  end

  // Row sample for the current column: how many rows read low, and which one.
  always_comb begin
    sampleLows = {2'b00, ~rowSync_q[0]} + {2'b00, ~rowSync_q[1]}
               + {2'b00, ~rowSync_q[2]} + {2'b00, ~rowSync_q[3]};
    sampleRow = 2'd0;
    if (!rowSync_q[3]) sampleRow = 2'd3;
    if (!rowSync_q[2]) sampleRow = 2'd2;
    if (!rowSync_q[1]) sampleRow = 2'd1;
    if (!rowSync_q[0]) sampleRow = 2'd0;
  end

  // Low count saturates at 2 (= multi-key); column 0 starts a new frame.
  // The candidate is only captured from the first and only low seen so far.
  always_comb begin
    baseLows  = (colIdx == 2'd0) ? 2'd0 : lowAcc_q;
    lowSum    = {1'b0, baseLows} + sampleLows;
    frameLows = (lowSum >= 3'd2) ? 2'd2 : lowSum[1:0];
    frameCand = (baseLows == 2'd0 && sampleLows == 3'd1) ? {sampleRow, colIdx} : candAcc_q;
    lowAcc_d  = tick ? frameLows : lowAcc_q;
    candAcc_d = tick ? frameCand : candAcc_q;
  end

  assign frameEval = tick && (colIdx == 2'd3);
  assign isEmpty   = (frameLows == 2'd0);
  assign isSingle  = (frameLows == 2'd1);
  assign cntInc    = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_d      = key_q;
    keyValid_d = 1'b0;
    if (frameEval) begin
      case (state_q)
        S_IDLE: begin
          if (isSingle) begin
            cand_d = frameCand;
            if (DEBOUNCE_FRAMES == 4'd1) begin
              state_d    = S_PRESSED;
              key_d      = frameCand;
              keyValid_d = 1'b1;
              cnt_d      = 4'd0;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          if (isSingle) begin
            if (frameCand == cand_q) begin
              cnt_d = cntInc;
              if (cntInc == DEBOUNCE_FRAMES) begin
                state_d    = S_PRESSED;
                key_d      = cand_q;
                keyValid_d = 1'b1;
                cnt_d      = 4'd0;
              end
            end else begin
              cand_d = frameCand;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end
        S_PRESSED: begin
          // No rollover: any non-empty frame keeps the current key.
          if (isEmpty) begin
            if (DEBOUNCE_FRAMES == 4'd1) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        default: begin
          if (isEmpty) begin
            cnt_d = cntInc;
            if (cntInc == DEBOUNCE_FRAMES) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
    keyHeld_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      divCnt_q   <= 26'd0;
      col_q      <= 4'b1110;
      rowMeta_q  <= 4'b1111;
      rowSync_q  <= 4'b1111;
      lowAcc_q   <= 2'd0;
      candAcc_q  <= 4'd0;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cand_q     <= 4'd0;
      key_q      <= 4'h0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      divCnt_q   <= divCnt_d;
      col_q      <= col_d;
      rowMeta_q  <= row;
      rowSync_q  <= rowMeta_q;
      lowAcc_q   <= lowAcc_d;
      candAcc_q  <= candAcc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      key_q      <= key_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule
